// File: rtl/xor_gate_if.sv
// Operand/result bundle for xor_gate: operands with in_valid in, registered result out.
// Latency: n/a (wires only); the producer drives operands, the xor_gate side drives results.
// Backpressure: none; out_valid is a one-cycle strobe the consumer must take immediately.
// Optional parity wire exists only when XOR_GATE_PARITY_EN is defined.
interface xor_gate_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic [N-1:0] A_num;
  logic [N-1:0] B_num;
  logic [N-1:0] result;
  logic         sign;
  logic         out_valid;
`ifdef XOR_GATE_PARITY_EN
  logic         parity;

  // Producer/consumer side of the XOR unit
  modport master (
    output in_valid, A_num, B_num,
    input  result, sign, out_valid, parity
  );

  // The XOR unit itself
  modport slave (
    input  in_valid, A_num, B_num,
    output result, sign, out_valid, parity
  );
`else
  // Producer/consumer side of the XOR unit
  modport master (
    output in_valid, A_num, B_num,
    input  result, sign, out_valid
  );

  // The XOR unit itself
  modport slave (
    input  in_valid, A_num, B_num,
    output result, sign, out_valid
  );
`endif
endinterface

// File: rtl/xor_gate.sv
// N-bit bitwise XOR with registered result, sign flag and valid strobe (optional parity via XOR_GATE_PARITY_EN).
// Latency: 1 cycle; operands accepted at edge k are on the outputs right after edge k, 1 op/cycle.
// Backpressure: none; out_valid is high only the cycle after each accepting edge, result/sign hold otherwise.
module xor_gate #(
  parameter int N = 4  // operand/result width, 1..64
) (
  input logic     clk,
  input logic     rst_n,
  xor_gate_if.slave bus
);

  logic [N-1:0] next_result;
  logic [N-1:0] result_q;
  logic         sign_q;
  logic         out_valid_q;
`ifdef XOR_GATE_PARITY_EN
  logic         parity_q;
`endif

  // Pure bitwise XOR: no carries, so there is no overflow to flag
  always_comb begin
    next_result = bus.A_num ^ bus.B_num;
  end

  // Output stage: capture on in_valid, otherwise hold data and drop the valid strobe.
  // Async reset discards anything in flight so it never reappears after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef XOR_GATE_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        result_q <= next_result;
        // MSB doubles as the two's-complement sign; for N=1 it is bit 0
        sign_q   <= next_result[N-1];
`ifdef XOR_GATE_PARITY_EN
        // 1 when the result carries an odd number of ones
        parity_q <= ^next_result;
`endif
      end
    end
  end

  // Every output is driven straight from a flop
  assign bus.result    = result_q;
  assign bus.sign      = sign_q;
  assign bus.out_valid = out_valid_q;
`ifdef XOR_GATE_PARITY_EN
  assign bus.parity    = parity_q;
`endif

endmodule

// File: tb/tb_xor_gate.sv
// Directed bench for xor_gate (N=4) with a queue-based scoreboard of expected outputs.
// Latency: expectations pushed when operands are driven, popped 1 cycle later.
// Backpressure: none exercised; the DUT has none.
module tb_xor_gate;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] res;
    logic         sgn;
    logic         par;
    logic         vld;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  exp_t sb[$];

  // Reference state: what the registered outputs should hold
  logic [N-1:0] m_res;
  logic         m_sign;
  logic         m_par;

  xor_gate_if #(.N(N)) bus ();

  xor_gate #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #100000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then check it after the edge
  task automatic step(input logic v, input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    exp_t e;
    bus.in_valid = v;
    bus.A_num    = a;
    bus.B_num    = b;
    if (v) begin
      m_res  = a ^ b;
      m_sign = m_res[N-1];
      m_par  = ^m_res;
    end
    e.res = m_res;
    e.sgn = m_sign;
    e.par = m_par;
    e.vld = v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".result"},    64'(bus.result),    64'(e.res));
    chk({tag, ".sign"},      64'(bus.sign),      64'(e.sgn));
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(e.vld));
`ifdef XOR_GATE_PARITY_EN
    chk({tag, ".parity"},    64'(bus.parity),    64'(e.par));
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".result"},    64'(bus.result),    64'd0);
    chk({tag, ".sign"},      64'(bus.sign),      64'd0);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
`ifdef XOR_GATE_PARITY_EN
    chk({tag, ".parity"},    64'(bus.parity),    64'd0);
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_res = '0;
    m_sign = 1'b0;
    m_par = 1'b0;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.A_num = '0;
    bus.B_num = '0;

    // Power-on reset, asserted before any clock edge
    #2 rst_n = 1'b0;
    #1 chk_zero("por");

    // Reset held across an edge with valid operands: outputs must stay zero
    bus.in_valid = 1'b1;
    bus.A_num = 4'h9;
    bus.B_num = 4'h3;
    @(posedge clk);
    #1 chk_zero("rst_hold");
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    // Truth sweep, back-to-back so out_valid stays high
    step(1'b1, 4'h0, 4'h0, "tt00");
    step(1'b1, 4'h0, 4'h1, "tt01");
    step(1'b1, 4'h1, 4'h0, "tt10");
    step(1'b1, 4'h1, 4'h1, "tt11");

    // Sign flag set then cleared
    step(1'b1, 4'b1000, 4'b0000, "sign1");
    step(1'b1, 4'hF, 4'hF, "sign0");

    // Hold: result stays F while inputs toggle with in_valid low
    step(1'b1, 4'hA, 4'h5, "cap_af");
    step(1'b0, 4'h1, 4'h2, "hold1");
    step(1'b0, 4'hE, 4'h7, "hold2");
    step(1'b0, 4'h8, 4'h0, "hold3");

    // Parity: odd then even population (result checks apply without the macro too)
    step(1'b1, 4'b0111, 4'b0000, "par_odd");
    step(1'b1, 4'b0110, 4'b0000, "par_even");

    // Mid-stream reset: stale nonzero outputs clear immediately, pending op is dropped
    step(1'b1, 4'h3, 4'h0, "mid_cap");
    bus.in_valid = 1'b1;
    bus.A_num = 4'h3;
    bus.B_num = 4'h0;
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_async");
    m_res = '0;
    m_sign = 1'b0;
    m_par = 1'b0;
    @(posedge clk);
    #1 chk_zero("rst_edge");
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 4'h3, 4'h0, "post_rst1");
    step(1'b0, 4'h5, 4'h6, "post_rst2");
    step(1'b1, 4'hC, 4'h6, "post_cap");

    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
